// File: rtl/operand_fetch_wb.sv
// Operand fetch / writeback stage: eight-entry register file, one issue
// pipeline register feeding a combinational function unit, writeback with
// same-cycle forwarding, and a V/C/N/Z status register.

// One register-file entry; written only from the writeback path.
module operand_fetch_wb_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture writeback data when this entry is the active destination.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end

endmodule

module operand_fetch_wb #(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [AW-1:0]    sa,
    input  logic [AW-1:0]    sb,
    input  logic [3:0]       fs_in,
    input  logic             mb,
    input  logic [WIDTH-1:0] const_in,
    input  logic [AW-1:0]    dst_in,
    input  logic             rw_in,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [3:0]       wb_flags,
    output logic             op_valid,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       FS,
    output logic [AW-1:0]    dst,
    output logic             rw,
    output logic [3:0]       status,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [NREG-1:0][WIDTH-1:0] regs;
    logic [NREG-1:0]            reg_we;
    logic                       wb_en;
    logic [WIDTH-1:0]           a_fwd;
    logic [WIDTH-1:0]           b_fwd;

    // The op in the pipeline register retires this cycle; its result is live.
    assign wb_en = op_valid & rw;

    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_reg
            assign reg_we[i] = wb_en && (dst == AW'(i));
            operand_fetch_wb_cell #(.WIDTH(WIDTH)) u_cell (
                .clk (clk),
                .rst (rst),
                .we  (reg_we[i]),
                .d   (wb_data),
                .q   (regs[i])
            );
        end
    endgenerate

    // Operand select: a result being written this cycle wins over the stale
    // register value, so a distance-1 dependent op sees it; the constant
    // path for B bypasses forwarding entirely.
    always_comb begin
        a_fwd = regs[sa];
        b_fwd = regs[sb];
        if (wb_en && (dst == sa)) a_fwd = wb_data;
        if (wb_en && (dst == sb)) b_fwd = wb_data;
        if (mb)                   b_fwd = const_in;
    end

    // Issue pipeline register; operand fields hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid <= 1'b0;
            A        <= '0;
            B        <= '0;
            FS       <= '0;
            dst      <= '0;
            rw       <= 1'b0;
        end else if (issue) begin
            op_valid <= 1'b1;
            A        <= a_fwd;
            B        <= b_fwd;
            FS       <= fs_in;
            dst      <= dst_in;
            rw       <= rw_in;
        end else begin
            op_valid <= 1'b0;
        end
    end

    // Status latches the unit's flags on retire; shifter ops (FS=11xx) leave it alone.
    always_ff @(posedge clk) begin
        if (rst)                            status <= '0;
        else if (op_valid && FS[3:2] != 2'b11) status <= wb_flags;
    end

    // Debug port reads the array directly: old value during the write cycle.
    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_operand_fetch_wb.sv
`timescale 1ns/1ps
module tb_operand_fetch_wb;

    logic       clk = 0;
    logic       rst, issue, mb, rw_in;
    logic [2:0] sa, sb, dst_in, dbg_addr;
    logic [3:0] fs_in, wb_flags;
    logic [7:0] const_in, wb_data;
    logic       op_valid, rw;
    logic [7:0] A, B, dbg_data;
    logic [3:0] FS, status;
    logic [2:0] dst;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  m_regs [8];
    logic        m_valid, m_rw;
    logic [2:0]  m_dst;
    logic [3:0]  m_fs, m_status;
    logic [7:0]  m_a, m_b;
    logic [15:0] exp_q [$];

    operand_fetch_wb dut (
        .clk(clk), .rst(rst), .issue(issue), .sa(sa), .sb(sb), .fs_in(fs_in),
        .mb(mb), .const_in(const_in), .dst_in(dst_in), .rw_in(rw_in),
        .wb_data(wb_data), .wb_flags(wb_flags), .op_valid(op_valid),
        .A(A), .B(B), .FS(FS), .dst(dst), .rw(rw), .status(status),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] fwd(input logic [2:0] x);
        return (m_valid && m_rw && m_dst == x) ? wb_data : m_regs[x];
    endfunction

    // Advance one clock: model next state, push expected operands on issue,
    // then pop and compare once the DUT has captured the operation.
    task automatic cyc();
        logic [7:0]  ea, eb;
        logic [15:0] e;
        if (rst) begin
            foreach (m_regs[k]) m_regs[k] = 8'h00;
            m_valid = 0; m_rw = 0; m_dst = 0; m_fs = 0; m_status = 0;
            m_a = 0; m_b = 0;
            exp_q.delete();
        end else begin
            ea = fwd(sa);
            eb = mb ? const_in : fwd(sb);
            if (m_valid && m_rw) m_regs[m_dst] = wb_data;
            if (m_valid && m_fs[3:2] != 2'b11) m_status = wb_flags;
            if (issue) begin
                exp_q.push_back({ea, eb});
                m_a = ea; m_b = eb;
                m_valid = 1; m_rw = rw_in; m_dst = dst_in; m_fs = fs_in;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (op_valid !== m_valid) begin
            errors++; $display("FAIL op_valid got %b exp %b", op_valid, m_valid);
        end
        checks++;
        if (status !== m_status) begin
            errors++; $display("FAIL status got %b exp %b", status, m_status);
        end
        checks++;
        if ({FS, dst, rw} !== {m_fs, m_dst, m_rw}) begin
            errors++; $display("FAIL ctrl got %h/%0d/%b exp %h/%0d/%b", FS, dst, rw, m_fs, m_dst, m_rw);
        end
        if (m_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL scoreboard empty got A=%h B=%h", A, B);
            end else begin
                e = exp_q.pop_front();
                if (A !== e[15:8] || B !== e[7:0]) begin
                    errors++; $display("FAIL operands got A=%h B=%h exp A=%h B=%h", A, B, e[15:8], e[7:0]);
                end
            end
        end else begin
            checks++;
            if (A !== m_a || B !== m_b) begin
                errors++; $display("FAIL hold got A=%h B=%h exp A=%h B=%h", A, B, m_a, m_b);
            end
        end
    endtask

    task automatic set_op(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                          input logic m, input logic [7:0] c, input logic [2:0] d, input logic w);
        issue = 1; fs_in = f; sa = a; sb = b; mb = m; const_in = c; dst_in = d; rw_in = w;
    endtask

    task automatic test_reset();
        rst = 1; issue = 1; rw_in = 1; dst_in = 3'd7; wb_data = 8'hAA; wb_flags = 4'hF;
        cyc(); cyc();
        rst = 0; issue = 0;
        checks++;
        if (op_valid !== 1'b0 || A !== 8'h00 || B !== 8'h00 || status !== 4'h0) begin
            errors++; $display("FAIL reset_state got v=%b A=%h B=%h st=%b exp 0", op_valid, A, B, status);
        end
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++; $display("FAIL reset_reg%0d got %h exp 00", a, dbg_data);
            end
        end
    endtask

    task automatic test_const_load();
        set_op(4'b0000, 3'd0, 3'd0, 1'b1, 8'h5A, 3'd3, 1'b1);
        cyc();
        issue = 0; wb_data = 8'h5A; wb_flags = 4'b0000;
        dbg_addr = 3'd3; #1;
        checks++;
        if (dbg_data !== 8'h00) begin
            errors++; $display("FAIL dbg_old_during_write got %h exp 00", dbg_data);
        end
        cyc();
        checks++;
        if (dbg_data !== 8'h5A) begin
            errors++; $display("FAIL const_wb reg3 got %h exp 5a", dbg_data);
        end
        set_op(4'b0000, 3'd3, 3'd0, 1'b0, 8'h00, 3'd6, 1'b0);
        cyc();
        issue = 0;
        checks++;
        if (A !== 8'h5A) begin
            errors++; $display("FAIL read_back A got %h exp 5a", A);
        end
        cyc();
    endtask

    task automatic test_forwarding();
        set_op(4'b0000, 3'd0, 3'd0, 1'b1, 8'h10, 3'd1, 1'b1);
        cyc();
        set_op(4'b0000, 3'd0, 3'd0, 1'b1, 8'h01, 3'd2, 1'b1);
        wb_data = 8'h10; wb_flags = 4'b0000;
        cyc();
        issue = 0; wb_data = 8'h01;
        cyc();
        set_op(4'b0010, 3'd1, 3'd2, 1'b0, 8'h00, 3'd1, 1'b1);
        cyc();
        set_op(4'b0000, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 1'b1);
        wb_data = 8'h11;
        cyc();
        checks++;
        if (A !== 8'h11 || B !== 8'h01) begin
            errors++; $display("FAIL fwd_A got A=%h B=%h exp A=11 B=01", A, B);
        end
        dbg_addr = 3'd1; #1;
        checks++;
        if (dbg_data !== 8'h11) begin
            errors++; $display("FAIL fwd_reg1 got %h exp 11", dbg_data);
        end
        // same register on both sources and destination
        set_op(4'b0000, 3'd3, 3'd3, 1'b0, 8'h00, 3'd0, 1'b1);
        wb_data = 8'h22;
        cyc();
        checks++;
        if (A !== 8'h22 || B !== 8'h22) begin
            errors++; $display("FAIL fwd_both got A=%h B=%h exp 22/22", A, B);
        end
        issue = 0; wb_data = 8'h33;
        cyc();
    endtask

    task automatic test_flags();
        set_op(4'b0010, 3'd0, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        cyc();
        issue = 0; wb_flags = 4'b0101;
        cyc();
        checks++;
        if (status !== 4'b0101) begin
            errors++; $display("FAIL alu_flags got %b exp 0101", status);
        end
        set_op(4'b1101, 3'd0, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        cyc();
        issue = 0; wb_flags = 4'b1111;
        cyc();
        checks++;
        if (status !== 4'b0101) begin
            errors++; $display("FAIL shift_flags got %b exp 0101", status);
        end
    endtask

    task automatic test_rw0_idle();
        logic [7:0] ha, hb;
        set_op(4'b0000, 3'd1, 3'd2, 1'b0, 8'h00, 3'd4, 1'b0);
        cyc();
        issue = 0; wb_data = 8'hFF;
        cyc();
        dbg_addr = 3'd4; #1;
        checks++;
        if (dbg_data !== 8'h00) begin
            errors++; $display("FAIL rw0_reg4 got %h exp 00", dbg_data);
        end
        ha = 8'h11; hb = 8'h01;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (op_valid !== 1'b0 || A !== ha || B !== hb) begin
                errors++; $display("FAIL idle_hold got v=%b A=%h B=%h exp 0/%h/%h", op_valid, A, B, ha, hb);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            set_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 3) == 0), 8'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 3) != 0));
            wb_data = 8'($urandom); wb_flags = 4'($urandom);
            cyc();
        end
        issue = 0; wb_data = 8'($urandom);
        cyc();
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            checks++;
            if (dbg_data !== m_regs[a]) begin
                errors++; $display("FAIL b2b_reg%0d got %h exp %h", a, dbg_data, m_regs[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_op(4'b0000, 3'd0, 3'd0, 1'b1, 8'h77, 3'd5, 1'b1);
        wb_data = 8'h00;
        cyc();
        issue = 0; rst = 1; wb_data = 8'h77; wb_flags = 4'b1010;
        cyc();
        rst = 0;
        dbg_addr = 3'd5; #1;
        checks++;
        if (dbg_data !== 8'h00 || status !== 4'h0) begin
            errors++; $display("FAIL reset_mid got reg5=%h st=%b exp 00/0000", dbg_data, status);
        end
        cyc();
    endtask

    initial begin
        rst = 1; issue = 0; mb = 0; rw_in = 0; sa = 0; sb = 0; dst_in = 0;
        fs_in = 0; const_in = 0; wb_data = 0; wb_flags = 0; dbg_addr = 0;
        test_reset();
        test_const_load();
        test_forwarding();
        test_flags();
        test_rw0_idle();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_wb.md
# operand_fetch_wb

Register-file and operand-fetch/writeback stage wrapped around the datapath function unit. It holds eight 8-bit general registers. On an issue it latches the two source operands (A, B), the 4-bit function select and the destination into a pipeline register that feeds the function unit. In the following cycle it writes the function unit's 8-bit result back and latches its V/C/N/Z flags into a status register. Same-cycle write-to-read forwarding allows a dependent operation every cycle.

## Interface
- WIDTH, 8, data width of registers, operands and writeback data
- NREG, 8, number of general registers (address width 3)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- issue  in  1  capture a new operation this cycle
- sa, sb  in  3 each  source register addresses for A and B
- fs_in  in  4  function select carried with the operation
- mb  in  1  1 = B operand taken from const_in instead of register sb
- const_in  in  8  constant operand
- dst_in  in  3  destination register
- rw_in  in  1  write-back enable for this operation
- wb_data  in  8  result F from the function unit
- wb_flags  in  4  {V,C,N,Z} from the function unit
- op_valid  out  1  pipeline register holds an operation being executed
- A, B  out  8 each  registered operands to the function unit
- FS  out  4  registered function select
- dst  out  3, rw  out  1  registered destination and write enable
- status  out  4  latched {V,C,N,Z}
- dbg_addr  in  3, dbg_data  out  8  combinational debug read of regs[dbg_addr]

## Operation
- Issue stage (cycle n, issue=1):
  - A <= fwd(sa).
  - B <= const_in if mb=1, else fwd(sb).
  - FS <= fs_in, dst <= dst_in, rw <= rw_in, op_valid <= 1.
- Issue low: op_valid <= 0. A, B, FS, dst and rw hold their values.
- fwd(x) = wb_data when op_valid & rw & (dst == x), else regs[x]. Forwarding applies independently to A and B. mb=1 bypasses forwarding for B.
- Writeback (cycle n+1, op_valid=1):
  - If rw=1: regs[dst] <= wb_data.
  - status <= wb_flags, unless FS[3:2] == 2'b11. Shifter operations leave status unchanged.
- op_valid=0: no register write and no status update, regardless of rw.
- All eight registers are writable. There is no hardwired zero register.
- Single write port. Register writes only ever come from the writeback path.
- dbg_data reads regs directly, with no forwarding. It shows the old value during the write cycle.

## Timing
- Reset (rst=1 at a clock edge), applied to every state element:
  - regs[0..7] = 0.
  - op_valid = 0, A = 0, B = 0, FS = 0, dst = 0, rw = 0, status = 0.
- Reset has priority over issue and writeback in the same cycle. An operation in flight during reset is dropped and its writeback does not occur.
- Latency: issue at edge n drives A/B/FS at n+1. The function unit is combinational, so the result is written at edge n+2 and is visible on dbg_data after edge n+2.
- Throughput: one issue per cycle. A back-to-back dependent operation (distance 1) gets the correct value through forwarding. Distance 2 or more reads the register file directly.
- Simultaneous issue and writeback to the same register: the newly captured operand equals wb_data, and the register is also updated.
- sa == sb == dst with forwarding active: both A and B receive wb_data.
- No backpressure. The function unit always accepts in one cycle.

## Test plan
- Reset: assert rst for 2 cycles with issue=1 and rw_in=1 -> op_valid=0, A=B=0, status=0, dbg_data=0 for all 8 addresses.
- Constant load and writeback:
  - Issue FS=0000 (transfer A) with sa=0, mb=1, const_in=8'h5A, dst=3, rw=1; bench drives wb_data=8'h5A -> regs[3]=8'h5A two cycles after issue.
  - A second issue with sa=3 -> A=8'h5A.
- Forwarding:
  - regs[1]=8'h10 and regs[2]=8'h01.
  - Issue add with dst=1; next cycle issue sa=1, sb=2 while wb_data=8'h11 -> A=8'h11, not 8'h10.
- Flags: execute an ALU op with wb_flags=4'b0101 -> status=0101. Then execute FS=4'b1101 (shift) with wb_flags=4'b1111 -> status stays 0101.
- rw=0 and idle:
  - Issue with rw=0, dst=4, wb_data=8'hFF -> regs[4] unchanged.
  - Deassert issue for 3 cycles -> op_valid=0 and A/B hold their values.
- Reset mid-operation: issue with dst=5, rw=1, then assert rst in the writeback cycle -> regs[5]=0 and status=0.
